// File: rtl/udp_rx_pkg.sv
// Shared constants for the UDP receive controller.
// State encodings and header sizes used by udp_rx_ctrl.
package udp_rx_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK_LEN = 3'd1;
  localparam logic [2:0] S_RD_HDR0   = 3'd2;
  localparam logic [2:0] S_RD_HDR1   = 3'd3;
  localparam logic [2:0] S_RD_DATA   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam int HDR_BYTES     = 2;
  localparam int UDP_HDR_BYTES = 8;

endpackage

// File: rtl/sat_cnt16.sv
// Saturating 16-bit event counter.
// clk_i/rst_i: clock, sync reset; inc_i: count enable; cnt_o: value.
module sat_cnt16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/udp_rx_ctrl.sv
// Reads a UDP payload from RAM and streams its pixels into a FIFO.
// In: clk, rst, valid/length, RAM data, fifo_full. Out: RAM addr,
// FIFO write, line_num, line/frame start, error/drop counters, busy.
module udp_rx_ctrl
  import udp_rx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1472,
  parameter int MIN_PAYLOAD = 3
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        udp_rec_data_valid,
  input  logic [15:0] udp_rec_data_length,
  output logic [10:0] udp_rec_ram_read_addr,
  input  logic [7:0]  udp_rec_ram_rdata,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  output logic [15:0] line_num,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] seq_err_cnt,
  output logic [15:0] pkt_drop_cnt,
  output logic        busy
);

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [10:0] addr_q, addr_d;
  logic        rd_vld_q, rd_vld_d;
  logic        lo_pend_q, lo_pend_d;
  logic        first_q, first_d;
  logic [15:0] code_q, code_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] line_num_q, line_num_d;

  logic [15:0] plen;
  logic        len_bad;
  logic        last_addr;
  logic        issue;
  logic        first_wr;
  logic        seq_bad;
  logic        drop_inc;
  logic        seq_inc;

  assign plen    = len_q - 16'(UDP_HDR_BYTES);
  assign len_bad = (len_q < 16'(UDP_HDR_BYTES))
                || (plen < 16'(MIN_PAYLOAD))
                || (plen > 16'(MAX_PAYLOAD));

  assign last_addr = ({5'd0, addr_q} == plen - 16'd1);
  assign issue     = (state_q == S_RD_DATA) && !fifo_full;
  assign first_wr  = rd_vld_q && first_q;
  assign seq_bad   = (code_q != 16'd1)
                  && (code_q != prev_q + 16'd1);

  // A rejected length and an ignored pulse can coincide in
  // CHECK_LEN; that cycle counts as a single drop.
  assign drop_inc = (udp_rec_data_valid && state_q != S_IDLE)
                 || (state_q == S_CHECK_LEN && len_bad);
  assign seq_inc  = first_wr && seq_bad;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    rd_vld_d   = issue;
    lo_pend_d  = lo_pend_q;
    first_d    = first_q;
    code_d     = code_q;
    prev_d     = prev_q;
    line_num_d = line_num_q;
    unique case (state_q)
      S_IDLE: begin
        if (udp_rec_data_valid) begin
          len_d   = udp_rec_data_length;
          state_d = S_CHECK_LEN;
        end
      end
      S_CHECK_LEN: begin
        if (len_bad) begin
          state_d = S_IDLE;
        end else begin
          addr_d  = '0;
          first_d = 1'b1;
          state_d = S_RD_HDR0;
        end
      end
      S_RD_HDR0: begin
        addr_d  = 11'd1;
        state_d = S_RD_HDR1;
      end
      S_RD_HDR1: begin
        code_d[15:8] = udp_rec_ram_rdata;
        addr_d       = 11'(HDR_BYTES);
        lo_pend_d    = 1'b1;
        state_d      = S_RD_DATA;
      end
      S_RD_DATA: begin
        // Byte 1 is on the bus only in the first RD_DATA cycle.
        if (lo_pend_q) begin
          code_d[7:0] = udp_rec_ram_rdata;
          lo_pend_d   = 1'b0;
        end
        if (!fifo_full) begin
          addr_d = addr_q + 11'd1;
          if (last_addr) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (first_wr) begin
      line_num_d = code_q;
      prev_d     = code_q;
      first_d    = 1'b0;
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      rd_vld_q   <= 1'b0;
      lo_pend_q  <= 1'b0;
      first_q    <= 1'b0;
      code_q     <= '0;
      prev_q     <= '0;
      line_num_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      rd_vld_q   <= rd_vld_d;
      lo_pend_q  <= lo_pend_d;
      first_q    <= first_d;
      code_q     <= code_d;
      prev_q     <= prev_d;
      line_num_q <= line_num_d;
    end
  end

  sat_cnt16 u_seq_cnt (
    .clk_i (gmii_rx_clk),
    .rst_i (rst),
    .inc_i (seq_inc),
    .cnt_o (seq_err_cnt)
  );

  sat_cnt16 u_drop_cnt (
    .clk_i (gmii_rx_clk),
    .rst_i (rst),
    .inc_i (drop_inc),
    .cnt_o (pkt_drop_cnt)
  );

  assign udp_rec_ram_read_addr = addr_q;
  assign fifo_wr_en   = rd_vld_q;
  assign fifo_wr_data = rd_vld_q ? udp_rec_ram_rdata : 8'h00;
  assign line_num     = line_num_q;
  assign line_start   = first_wr;
  assign frame_start  = first_wr && (code_q == 16'd1);
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_udp_rx_ctrl.sv
// Self-checking bench for udp_rx_ctrl.
// Table vectors, corner sequences, randomized packets vs a model.
module tb_udp_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] len_in;
  logic [10:0] addr;
  logic [7:0]  rdata;
  logic        ff;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [15:0] ln, seq, drop;
  logic        ls, fs, busy;

  always #5 clk = ~clk;

  udp_rx_ctrl #(
    .MAX_PAYLOAD(1472),
    .MIN_PAYLOAD(3)
  ) dut (
    .gmii_rx_clk          (clk),
    .rst                  (rst),
    .udp_rec_data_valid   (valid),
    .udp_rec_data_length  (len_in),
    .udp_rec_ram_read_addr(addr),
    .udp_rec_ram_rdata    (rdata),
    .fifo_full            (ff),
    .fifo_wr_en           (wr_en),
    .fifo_wr_data         (wr_data),
    .line_num             (ln),
    .line_start           (ls),
    .frame_start          (fs),
    .seq_err_cnt          (seq),
    .pkt_drop_cnt         (drop),
    .busy                 (busy)
  );

  logic [7:0] mem [0:2047];
  always @(posedge clk) rdata <= mem[addr];

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       ls;
    logic       fs;
    int         cyc;
  } obs_t;
  obs_t obs[$];
  int stray;

  always @(negedge clk) begin
    if (wr_en) obs.push_back('{wr_data, ls, fs, cyc});
    else if (ls || fs) stray <= stray + 1;
  end

  int ff_mode;
  int ph;
  initial begin
    ff = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ff_mode)
        0: ff = 1'b0;
        1: begin
          ff = ((ph % 6) >= 3);
          ph = ph + 1;
        end
        default: ff = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks, errors;
  int obs_idx;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    obs_idx = obs.size();
  endtask

  task automatic send(input logic [15:0] len,
                      input logic [15:0] code,
                      input bit ramp,
                      output int vc);
    int plen;
    plen = int'(len) - 8;
    mem[0] = code[15:8];
    mem[1] = code[7:0];
    if (plen >= 3 && plen <= 2048)
      for (int i = 2; i < plen; i++)
        mem[i] = ramp ? 8'(8'hA0 + i - 2) : 8'($urandom);
    @(posedge clk); #1;
    len_in = len;
    valid = 1'b1;
    vc = cyc;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic await_idle(output int dc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    dc = cyc;
    chk("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic check_pkt(input logic [15:0] len,
                           input logic [15:0] code,
                           input bit acc,
                           input logic [15:0] e_seq,
                           input logic [15:0] e_drop,
                           input logic [15:0] e_ln,
                           input bit lat,
                           input int vc,
                           input string tag);
    int dc, n, en, bad, plen;
    bit els, efs;
    await_idle(dc);
    @(negedge clk);
    plen = int'(len) - 8;
    en = acc ? plen - 2 : 0;
    n = obs.size() - obs_idx;
    chk({tag, "_nwr"}, n, en);
    if (acc && n > 0) begin
      bad = 0;
      for (int k = 0; k < n && k < en; k++) begin
        els = (k == 0);
        efs = (k == 0) && (code == 16'd1);
        if (obs[obs_idx + k].d !== mem[2 + k] ||
            obs[obs_idx + k].ls !== els ||
            obs[obs_idx + k].fs !== efs)
          bad++;
      end
      chk({tag, "_data_bad"}, bad, 0);
      if (lat)
        chk({tag, "_latency"}, obs[obs_idx].cyc - vc, 5);
    end
    if (!acc)
      chk({tag, "_busy_2cyc"}, 32'((dc - vc) <= 2), 32'd1);
    chk({tag, "_line_num"}, 32'(ln), 32'(e_ln));
    chk({tag, "_seq_err"}, 32'(seq), 32'(e_seq));
    chk({tag, "_drop"}, 32'(drop), 32'(e_drop));
    obs_idx = obs.size();
  endtask

  typedef struct {
    logic [15:0] len;
    logic [15:0] code;
    bit          acc;
    logic [15:0] seq;
    logic [15:0] drop;
    logic [15:0] ln;
  } vec_t;
  vec_t tbl [12];

  logic [15:0] m_prev, m_seq, m_drop, m_ln;

  initial begin
    int vc, sz, plen;
    logic [15:0] len, code;
    bit acc;

    tbl[0]  = '{16'd18,   16'h0001, 1'b1, 16'd0, 16'd0, 16'h0001};
    tbl[1]  = '{16'd20,   16'h0002, 1'b1, 16'd0, 16'd0, 16'h0002};
    tbl[2]  = '{16'd11,   16'h0004, 1'b1, 16'd1, 16'd0, 16'h0004};
    tbl[3]  = '{16'd10,   16'h0005, 1'b0, 16'd1, 16'd1, 16'h0004};
    tbl[4]  = '{16'd1490, 16'h0005, 1'b0, 16'd1, 16'd2, 16'h0004};
    tbl[5]  = '{16'd1480, 16'h0005, 1'b1, 16'd1, 16'd2, 16'h0005};
    tbl[6]  = '{16'd5,    16'h0006, 1'b0, 16'd1, 16'd3, 16'h0005};
    tbl[7]  = '{16'd8,    16'h0006, 1'b0, 16'd1, 16'd4, 16'h0005};
    tbl[8]  = '{16'hFFFF, 16'h0006, 1'b0, 16'd1, 16'd5, 16'h0005};
    tbl[9]  = '{16'd12,   16'hFFFF, 1'b1, 16'd2, 16'd5, 16'hFFFF};
    tbl[10] = '{16'd12,   16'h0000, 1'b1, 16'd2, 16'd5, 16'h0000};
    tbl[11] = '{16'd12,   16'h0001, 1'b1, 16'd2, 16'd5, 16'h0001};

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    rst = 1'b1;
    valid = 1'b0;
    len_in = '0;
    ff_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_line_num", 32'(ln), 0);
    chk("rst_seq", 32'(seq), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_line_start", 32'(ls), 0);
    chk("rst_frame_start", 32'(fs), 0);
    obs_idx = obs.size();

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].len, tbl[i].code, i == 0, vc);
      check_pkt(tbl[i].len, tbl[i].code, tbl[i].acc,
                tbl[i].seq, tbl[i].drop, tbl[i].ln,
                1'b1, vc, $sformatf("tbl%0d", i));
    end

    ff_mode = 1;
    send(16'd1008, 16'd2, 1'b0, vc);
    check_pkt(16'd1008, 16'd2, 1'b1, 16'd2, 16'd5, 16'd2,
              1'b0, vc, "backpressure");
    ff_mode = 0;

    send(16'd108, 16'd3, 1'b0, vc);
    repeat (15) @(posedge clk);
    #1;
    len_in = 16'd18;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check_pkt(16'd108, 16'd3, 1'b1, 16'd2, 16'd6, 16'd3,
              1'b1, vc, "busy_pulse");

    send(16'd208, 16'd4, 1'b0, vc);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    sz = obs.size();
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_seq", 32'(seq), 0);
    chk("midrst_drop", 32'(drop), 0);
    chk("midrst_line_num", 32'(ln), 0);
    repeat (8) @(negedge clk);
    chk("midrst_no_writes", obs.size() - sz, 0);
    obs_idx = obs.size();
    send(16'd30, 16'd5, 1'b0, vc);
    check_pkt(16'd30, 16'd5, 1'b1, 16'd1, 16'd0, 16'd5,
              1'b1, vc, "after_rst");
    send(16'd20, 16'd1, 1'b0, vc);
    check_pkt(16'd20, 16'd1, 1'b1, 16'd1, 16'd0, 16'd1,
              1'b1, vc, "after_rst_f1");

    do_reset();
    m_prev = '0;
    m_seq = '0;
    m_drop = '0;
    m_ln = '0;
    ff_mode = 2;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: len = 16'($urandom_range(0, 10));
        1: len = 16'($urandom_range(1481, 1581));
        default: len = 16'($urandom_range(11, 131));
      endcase
      case ($urandom_range(0, 4))
        0: code = 16'd1;
        1: code = 16'($urandom);
        default: code = m_prev + 16'd1;
      endcase
      plen = int'(len) - 8;
      acc = (len >= 16'd8) && plen >= 3 && plen <= 1472;
      if (acc) begin
        if (code != 16'd1 && code != m_prev + 16'd1 &&
            m_seq != 16'hFFFF)
          m_seq = m_seq + 16'd1;
        m_prev = code;
        m_ln = code;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
      send(len, code, 1'b0, vc);
      check_pkt(len, code, acc, m_seq, m_drop, m_ln,
                1'b0, vc, $sformatf("rnd%0d", i));
    end
    ff_mode = 0;

    chk("stray_start_pulse", stray, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
